cpu_sequencer: RTL and testbench
================================

# cpu_sequencer

Multi-cycle control sequencer for the single-issue CPU core. It owns the program counter and instruction register, and fetches each instruction from instruction memory over a valid/ready handshake. It presents the instruction to the combinational decoder, launches the ALU when the decoded operation requires it, and selects the next PC (PC+4 or PC+immediate). It parks the core in a terminal halted state when the decoder flags a halt encoding.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request when high with valid.
- imem_addr  out  32  fetch address, equal to pc.
- imem_rsp_valid  in  1  fetch data valid.
- imem_rsp_data  in  32  fetched instruction word.
- dec_encode  out  32  instruction register, driven to the decoder.
- dec_alu_control  in  3  decoder ALU op; 3'b000 means no ALU operation.
- dec_next_pc  in  1  decoder PC select: 1 = PC+imm, 0 = PC+4.
- dec_is_halt  in  1  decoder halt flag.
- alu_start  out  1  single-cycle ALU launch pulse.
- alu_op  out  3  latched ALU op, stable from alu_start until alu_done.
- alu_done  in  1  ALU completion pulse.
- pc  out  32  current program counter.
- halted  out  1  high while in HALTED.
- instr_retired  out  32  count of completed non-halt instructions.

## Operation
States: FETCH, WAIT_RSP, DECODE, EXEC, EXEC_WAIT, UPDATE, HALTED.
- **Reset:**
  - pc=RESET_PC, ir=0, alu_op=0, instr_retired=0, state=FETCH.
  - All outputs are driven from these values: imem_req_valid=1 in FETCH, alu_start=0, halted=0.
- **FETCH:**
  - imem_req_valid=1 and imem_addr=pc.
  - On valid&&ready, go to WAIT_RSP.
  - imem_rsp_valid is ignored in this state.
- **WAIT_RSP:**
  - imem_req_valid=0.
  - On imem_rsp_valid: ir<=imem_rsp_data, go to DECODE.
- **DECODE:**
  - dec_encode=ir. Decoder outputs are sampled this cycle.
  - Latch alu_op<=dec_alu_control and the PC-select bit.
  - Next state:
    - dec_is_halt=1 → HALTED. This takes priority over all other fields.
    - dec_alu_control!=0 → EXEC.
    - otherwise → UPDATE.
- **EXEC:**
  - alu_start=1 for exactly this cycle, then go to EXEC_WAIT.
- **EXEC_WAIT:**
  - Wait for alu_done, then go to UPDATE.
  - An alu_done arriving during EXEC is ignored.
- **UPDATE:**
  - pc<=pc+4 if select=0.
  - pc<=pc+imm if select=1, where imm = sign-extend(ir[31:6]) << 2.
  - instr_retired<=instr_retired+1.
  - Go to FETCH.
- **HALTED:**
  - Terminal state; only rst exits it.
  - halted=1, no requests, no alu_start. pc holds the halt instruction's address.

Arithmetic rules:
- All PC arithmetic is 32-bit modulo 2^32; wrap-around is silent.
- instr_retired wraps at 2^32.

## Timing
- Instruction latency with zero-wait memory and ALU (ready=1 in FETCH, rsp one cycle later, alu_done one cycle after alu_start):
  - ALU op: 6 cycles (FETCH, WAIT_RSP, DECODE, EXEC, EXEC_WAIT, UPDATE).
  - Non-ALU op: 4 cycles.
- Fetch handshake:
  - imem_req_valid stays high, with a stable imem_addr, until accepted.
  - Exactly one request is outstanding at a time.
  - The response must arrive at least one cycle after acceptance.
- The new pc is visible on imem_addr in the first FETCH cycle after UPDATE.
- Reset mid-operation:
  - Any outstanding fetch or ALU operation is abandoned.
  - A late imem_rsp_valid arriving in FETCH is ignored.
  - A late alu_done arriving in any state other than EXEC_WAIT is ignored.
- Backpressure: imem_req_ready low holds FETCH indefinitely, with no timeout.

## Structure
- Shared package cpu_pkg holds:
  - state enum;
  - NEXT_PC_IMM=1'b1 and NEXT_PC_4=1'b0;
  - ALU_NOP=3'b000, ALU_ADD=3'b010, ALU_SUB=3'b110;
  - HALT_ENCODE=32'h0000_003F.
- Natural sub-module: cpu_pc_unit, holding the pc register, the +4/+imm adders, the immediate extraction and the reset load.
- The sequencer instantiates cpu_pc_unit and holds the FSM, the ir and alu_op registers, and the retire counter. It does not instantiate the decoder; the decoder is connected at core top level.

## Test plan
- **Reset and first fetch:** assert rst 2 cycles with RESET_PC=32'h100 → imem_req_valid=1, imem_addr=32'h100, halted=0, instr_retired=0 on the first cycle after reset.
- **ALU instruction:** respond 32'h0 with decoder alu_control=3'b010, next_pc=0, and alu_done one cycle after alu_start → a single-cycle alu_start with alu_op=3'b010; pc becomes 32'h104 six cycles after the FETCH; instr_retired=1.
- **Immediate branch with wrap:** pc=32'hFFFF_FFFC, ir=32'h0000_0077 (imm field 1 → +4), decoder next_pc=1, alu_control=0 → no alu_start; pc becomes 32'h0000_0000 four cycles after the FETCH.
- **Backpressure and slow ALU:** hold imem_req_ready=0 for 5 cycles, then delay alu_done by 7 cycles, and pulse alu_done during EXEC → address stable throughout, exactly one request issued, the early alu_done ignored, UPDATE only after the real alu_done.
- **Halt:** respond 32'h3F with decoder is_halt=1 → HALTED the cycle after DECODE; halted=1; no further imem_req_valid for 20 cycles; pc and instr_retired unchanged.
- **Reset mid-operation:** assert rst in EXEC_WAIT, then pulse alu_done and imem_rsp_valid in the first FETCH cycle after reset → FSM stays in FETCH; pc=RESET_PC; ir not updated; instr_retired=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the cpu sequencer slice
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_WAIT_RSP,
        ST_DECODE,
        ST_EXEC,
        ST_EXEC_WAIT,
        ST_UPDATE,
        ST_HALTED
    } state_e;

    localparam logic        NEXT_PC_IMM = 1'b1;
    localparam logic        NEXT_PC_4   = 1'b0;

    localparam logic [2:0]  ALU_NOP     = 3'b000;
    localparam logic [2:0]  ALU_ADD     = 3'b010;
    localparam logic [2:0]  ALU_SUB     = 3'b110;

    localparam logic [31:0] HALT_ENCODE = 32'h0000_003F;

    // Branch offset: 26-bit signed field scaled to a word offset.
    function automatic logic [31:0] branch_imm(input logic [25:0] field);
        return {{4{field[25]}}, field, 2'b00};
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// rtl/cpu_sequencer_if.sv - fetch, decoder and alu signals of the sequencer
interface cpu_sequencer_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] dec_encode;
    logic [2:0]  dec_alu_control;
    logic        dec_next_pc;
    logic        dec_is_halt;
    logic        alu_start;
    logic [2:0]  alu_op;
    logic        alu_done;

    modport master (
        output imem_req_valid, imem_addr, dec_encode, alu_start, alu_op,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  dec_alu_control, dec_next_pc, dec_is_halt, alu_done
    );

    modport slave (
        input  imem_req_valid, imem_addr, dec_encode, alu_start, alu_op,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output dec_alu_control, dec_next_pc, dec_is_halt, alu_done
    );
endinterface

// File: rtl/cpu_pc_unit.sv
// rtl/cpu_pc_unit.sv - program counter register with +4 / +imm next-pc select
module cpu_pc_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        upd_en,
    input  logic        sel,
    input  logic [25:0] imm_field,
    output logic [31:0] pc
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    // Both adders wrap silently at 2^32.
    always_comb begin
        pc_d = pc_q;
        if (upd_en) begin
            if (sel == NEXT_PC_IMM) begin
                pc_d = pc_q + branch_imm(imm_field);
            end else begin
                pc_d = pc_q + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle fetch/decode/execute control sequencer
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    cpu_sequencer_if.master bus,
    output logic [31:0]     pc,
    output logic            halted,
    output logic [31:0]     instr_retired
);

    state_e      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [2:0]  alu_op_q, alu_op_d;
    logic        sel_q, sel_d;
    logic [31:0] retired_q, retired_d;
    logic        pc_upd;

    cpu_pc_unit #(
        .RESET_PC (RESET_PC)
    ) u_pc_unit (
        .clk       (clk),
        .rst       (rst),
        .upd_en    (pc_upd),
        .sel       (sel_q),
        .imm_field (ir_q[31:6]),
        .pc        (pc)
    );

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        alu_op_d  = alu_op_q;
        sel_d     = sel_q;
        retired_d = retired_q;
        pc_upd    = 1'b0;

        case (state_q)
            ST_FETCH: begin
                if (bus.imem_req_ready) begin
                    state_d = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                if (bus.imem_rsp_valid) begin
                    ir_d    = bus.imem_rsp_data;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                alu_op_d = bus.dec_alu_control;
                sel_d    = bus.dec_next_pc;
                // Halt wins over any ALU or branch field in the same word.
                if (bus.dec_is_halt) begin
                    state_d = ST_HALTED;
                end else if (bus.dec_alu_control != ALU_NOP) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_UPDATE;
                end
            end
            ST_EXEC: begin
                state_d = ST_EXEC_WAIT;
            end
            ST_EXEC_WAIT: begin
                if (bus.alu_done) begin
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                pc_upd    = 1'b1;
                retired_d = retired_q + 32'd1;
                state_d   = ST_FETCH;
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            ir_q      <= 32'h0;
            alu_op_q  <= ALU_NOP;
            sel_q     <= NEXT_PC_4;
            retired_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            alu_op_q  <= alu_op_d;
            sel_q     <= sel_d;
            retired_q <= retired_d;
        end
    end

    assign bus.imem_req_valid = (state_q == ST_FETCH);
    assign bus.imem_addr      = pc;
    assign bus.dec_encode     = ir_q;
    assign bus.alu_start      = (state_q == ST_EXEC);
    assign bus.alu_op         = alu_op_q;
    assign halted             = (state_q == ST_HALTED);
    assign instr_retired      = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - directed self-checking bench for cpu_sequencer
module tb_cpu_sequencer;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        halted;
    logic [31:0] instr_retired;

    int n_checks = 0;
    int n_fail   = 0;
    int hs_count = 0;
    int st_count = 0;
    int hs_base;
    int st_base;
    logic saw_bad;

    cpu_sequencer_if ifc ();

    cpu_sequencer #(
        .RESET_PC (32'h0000_0100)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (ifc),
        .pc            (pc),
        .halted        (halted),
        .instr_retired (instr_retired)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst) begin
            if (ifc.imem_req_valid && ifc.imem_req_ready) hs_count++;
            if (ifc.alu_start) st_count++;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst                 = 1'b1;
        ifc.imem_req_ready  = 1'b0;
        ifc.imem_rsp_valid  = 1'b0;
        ifc.imem_rsp_data   = 32'h0;
        ifc.dec_alu_control = ALU_NOP;
        ifc.dec_next_pc     = NEXT_PC_4;
        ifc.dec_is_halt     = 1'b0;
        ifc.alu_done        = 1'b0;

        // Reset and first fetch
        step();
        step();
        rst = 1'b0;
        chk("rst_req_valid", 32'(ifc.imem_req_valid), 32'd1);
        chk("rst_addr", ifc.imem_addr, 32'h100);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_retired", instr_retired, 32'd0);
        chk("rst_alu_start", 32'(ifc.alu_start), 32'd0);
        chk("rst_encode", ifc.dec_encode, 32'h0);

        // ALU instruction, zero-wait
        ifc.imem_req_ready  = 1'b1;
        ifc.dec_alu_control = ALU_ADD;
        ifc.dec_next_pc     = NEXT_PC_4;
        st_base = st_count;
        step();
        chk("alu_wait_valid", 32'(ifc.imem_req_valid), 32'd0);
        ifc.imem_rsp_valid = 1'b1;
        ifc.imem_rsp_data  = 32'h0;
        step();
        ifc.imem_rsp_valid = 1'b0;
        chk("alu_dec_start", 32'(ifc.alu_start), 32'd0);
        step();
        chk("alu_exec_start", 32'(ifc.alu_start), 32'd1);
        chk("alu_exec_op", 32'(ifc.alu_op), 32'(ALU_ADD));
        step();
        chk("alu_wait_start", 32'(ifc.alu_start), 32'd0);
        chk("alu_wait_op", 32'(ifc.alu_op), 32'(ALU_ADD));
        ifc.alu_done = 1'b1;
        step();
        ifc.alu_done = 1'b0;
        chk("alu_upd_pc", pc, 32'h100);
        step();
        chk("alu_pc", pc, 32'h104);
        chk("alu_addr", ifc.imem_addr, 32'h104);
        chk("alu_retired", instr_retired, 32'd1);
        chk("alu_req_valid", 32'(ifc.imem_req_valid), 32'd1);
        chk("alu_start_count", 32'(st_count - st_base), 32'd1);

        // Backward branch 0x104 -> 0xFFFF_FFFC
        ifc.dec_alu_control = ALU_NOP;
        ifc.dec_next_pc     = NEXT_PC_IMM;
        st_base = st_count;
        step();
        ifc.imem_rsp_valid = 1'b1;
        ifc.imem_rsp_data  = 32'hFFFF_EF80;
        step();
        ifc.imem_rsp_valid = 1'b0;
        chk("neg_encode", ifc.dec_encode, 32'hFFFF_EF80);
        step();
        step();
        chk("neg_pc", pc, 32'hFFFF_FFFC);
        chk("neg_retired", instr_retired, 32'd2);

        // Immediate branch with wrap: 0xFFFF_FFFC + 4 -> 0
        step();
        ifc.imem_rsp_valid = 1'b1;
        ifc.imem_rsp_data  = 32'h0000_0077;
        step();
        ifc.imem_rsp_valid = 1'b0;
        step();
        step();
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_addr", ifc.imem_addr, 32'h0);
        chk("wrap_retired", instr_retired, 32'd3);
        chk("wrap_no_alu_start", 32'(st_count - st_base), 32'd0);

        // Backpressure and slow ALU
        ifc.imem_req_ready  = 1'b0;
        ifc.dec_alu_control = ALU_SUB;
        ifc.dec_next_pc     = NEXT_PC_4;
        hs_base = hs_count;
        st_base = st_count;
        saw_bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ifc.imem_rsp_valid = (i == 2);
            ifc.imem_rsp_data  = 32'hDEAD_BEEF;
            step();
            if (!ifc.imem_req_valid || ifc.imem_addr !== 32'h0) saw_bad = 1'b1;
        end
        ifc.imem_rsp_valid = 1'b0;
        chk("bp_addr_stable", 32'(saw_bad), 32'd0);
        chk("bp_rsp_ignored", ifc.dec_encode, 32'h0000_0077);
        ifc.imem_req_ready = 1'b1;
        step();
        ifc.imem_rsp_valid = 1'b1;
        ifc.imem_rsp_data  = 32'h0000_1000;
        step();
        ifc.imem_rsp_valid = 1'b0;
        step();
        chk("bp_exec_start", 32'(ifc.alu_start), 32'd1);
        chk("bp_exec_op", 32'(ifc.alu_op), 32'(ALU_SUB));
        ifc.alu_done = 1'b1;
        step();
        ifc.alu_done = 1'b0;
        saw_bad = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (ifc.imem_req_valid || ifc.alu_start || pc !== 32'h0) saw_bad = 1'b1;
            step();
        end
        chk("bp_early_done_ignored", 32'(saw_bad), 32'd0);
        ifc.alu_done = 1'b1;
        step();
        ifc.alu_done = 1'b0;
        chk("bp_upd_pc", pc, 32'h0);
        step();
        chk("bp_pc", pc, 32'h4);
        chk("bp_retired", instr_retired, 32'd4);
        chk("bp_one_request", 32'(hs_count - hs_base), 32'd1);
        chk("bp_one_start", 32'(st_count - st_base), 32'd1);

        // Halt, with ALU and branch fields also set
        ifc.dec_is_halt     = 1'b1;
        ifc.dec_alu_control = ALU_ADD;
        ifc.dec_next_pc     = NEXT_PC_IMM;
        step();
        ifc.imem_rsp_valid = 1'b1;
        ifc.imem_rsp_data  = HALT_ENCODE;
        step();
        ifc.imem_rsp_valid = 1'b0;
        chk("halt_encode", ifc.dec_encode, HALT_ENCODE);
        chk("halt_not_yet", 32'(halted), 32'd0);
        hs_base = hs_count;
        st_base = st_count;
        step();
        chk("halt_halted", 32'(halted), 32'd1);
        saw_bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (ifc.imem_req_valid || !halted) saw_bad = 1'b1;
        end
        chk("halt_quiet", 32'(saw_bad), 32'd0);
        chk("halt_no_req", 32'(hs_count - hs_base), 32'd0);
        chk("halt_no_start", 32'(st_count - st_base), 32'd0);
        chk("halt_pc", pc, 32'h4);
        chk("halt_retired", instr_retired, 32'd4);

        // Reset mid-operation from EXEC_WAIT
        rst = 1'b1;
        ifc.dec_is_halt     = 1'b0;
        ifc.dec_alu_control = ALU_ADD;
        ifc.dec_next_pc     = NEXT_PC_4;
        step();
        rst = 1'b0;
        chk("mid_rst_halted", 32'(halted), 32'd0);
        chk("mid_rst_pc", pc, 32'h100);
        step();
        ifc.imem_rsp_valid = 1'b1;
        ifc.imem_rsp_data  = 32'h1234_5678;
        step();
        ifc.imem_rsp_valid = 1'b0;
        step();
        step();
        chk("mid_in_exec_wait", 32'(ifc.imem_req_valid | ifc.alu_start), 32'd0);
        chk("mid_encode_before", ifc.dec_encode, 32'h1234_5678);
        rst = 1'b1;
        step();
        rst = 1'b0;
        ifc.imem_req_ready = 1'b0;
        ifc.alu_done       = 1'b1;
        ifc.imem_rsp_valid = 1'b1;
        ifc.imem_rsp_data  = 32'hCAFE_BABE;
        step();
        ifc.alu_done       = 1'b0;
        ifc.imem_rsp_valid = 1'b0;
        chk("mid_fetch_valid", 32'(ifc.imem_req_valid), 32'd1);
        chk("mid_pc", pc, 32'h100);
        chk("mid_encode", ifc.dec_encode, 32'h0);
        chk("mid_retired", instr_retired, 32'd0);
        chk("mid_alu_start", 32'(ifc.alu_start), 32'd0);
        step();
        chk("mid_still_fetch", 32'(ifc.imem_req_valid), 32'd1);
        chk("mid_addr", ifc.imem_addr, 32'h100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
